cpu_clock_gen: RTL
==================

// Module: cpu_clock_gen
// PURPOSE
//  Multi-channel, runtime-programmable clock generator fed by the PLL output clock.
//  Divides sys_clk by a per-channel integer N; divisor changes are glitch-free.
//  Each channel supports run/halt and single-step control for CPU/bus clocks (Z80 CLK, peripherals).
//  Each channel also emits a one-cycle rising-edge strobe for sys_clk-domain logic.
// PARAMETERS
//  NCH        2    number of output channels
//  DIVW       8    divisor width in bits; N range is 2..2^DIVW-1
//  DIV_INIT   4    divisor loaded into every channel at reset
//  LOCK_WAIT  16   consecutive sys_clk cycles pll_lock must be high before outputs start
// PORTS
//  sys_clk     in   1         clock, the PLL output
//  reset_n     in   1         asynchronous active-low reset
//  pll_lock    in   1         PLL lock indicator; asynchronous, synchronised internally (2 FF)
//  div_val     in   NCH*DIVW  divisor per channel; channel c uses bits [c*DIVW +: DIVW]
//  div_load    in   NCH       1-cycle pulse: capture div_val[c] as the pending divisor of channel c
//  run         in   NCH       1 = free-running; 0 = halt at the next period boundary
//  step        in   NCH       1-cycle pulse while halted: emit exactly one full period
//  clk_out     out  NCH       generated clocks; registered outputs
//  rise_stb    out  NCH       1-cycle pulse in the sys_clk cycle where clk_out[c] goes 0->1
//  ready       out  1         1 when lock qualification is complete
// BEHAVIOUR
//  Reset: clk_out=0, rise_stb=0, ready=0; every divisor and pending divisor = DIV_INIT; state WAIT_LOCK.
//  Lock qualifier:
//   - Counter counts consecutive cycles of synchronised pll_lock=1.
//   - Reaching LOCK_WAIT sets ready=1 on the next cycle.
//   - pll_lock=0 clears the counter.
//   - ready falls 1 cycle after synchronised lock loss.
//  Per-channel counter cnt runs 0..N-1. clk_out = (cnt < N>>1) ? 1 : 0. High phase comes first.
//   - N=2 gives 1/1; N=3 gives 1 high / 2 low; N=5 gives 2 high / 3 low.
//  Period boundary: cnt==N-1. At the boundary, cnt returns to 0.
//  rise_stb asserts in the same cycle clk_out becomes 1 (cnt 0 entered, channel active).
//  Divisor update:
//   - div_load latches the pending divisor.
//   - The pending divisor moves into N only at a period boundary, or on leaving IDLE.
//   - The current period is never shortened or stretched.
//   - Loaded value 0 or 1 is clamped to 2.
//   - A second div_load before the boundary overwrites the pending value (last write wins).
//  States per channel:
//   - WAIT_LOCK: clk_out=0, cnt=0. Go to RUN on ready & run[c], or to IDLE on ready & !run[c].
//   - RUN: free-running. run[c]=0 is sampled at the boundary -> IDLE.
//   - IDLE: clk_out=0.
//     - run[c]=1 -> RUN with cnt=0; first high phase starts the next cycle.
//     - step[c] -> STEP.
//   - STEP: exactly one period (cnt 0..N-1), then back to IDLE.
//     - step pulses during STEP are ignored.
//     - run[c]=1 during STEP -> RUN at the boundary.
//  Lock loss (ready 1->0): every active channel finishes its current period, then enters WAIT_LOCK.
//   - No runt pulse is produced.
//  step and run asserted together in IDLE: run wins; step is dropped.
//  Async reset mid-period: clk_out=0 immediately; truncation of the output is accepted.
//  Channels are fully independent; no phase relationship between channels is guaranteed.
// CONFIGURATION
//  CLKGEN_CYCLE_CNT_EN:
//   - Defined: adds output port cycle_cnt [NCH*32]. It is a free-running 32-bit count of rise_stb per channel.
//   - cycle_cnt resets to 0, wraps 0xFFFFFFFF -> 0, and holds while the channel is not emitting.
//   - Not defined: no port and no counter logic.
// TESTING
//  1. Assert pll_lock at t0 -> ready=1 exactly LOCK_WAIT+3 cycles later; clk_out stays 0 before that.
//  2. N=4, run=1 -> clk_out pattern 1100 repeating; rise_stb every 4th cycle, aligned with the 0->1 edge.
//  3. Running at N=4, div_load N=7 mid-period -> current 4-cycle period completes, then 3 high / 4 low.
//  4. div_load 0 and 1 -> both clamp to N=2 (pattern 10).
//  5. run=0 in IDLE, step pulse at N=6 -> exactly one 3-high/3-low period, then IDLE.
//     - A second step during the pulse produces no extra period.
//  6. Drop pll_lock mid high phase at N=8 -> period completes (4 high/4 low), then outputs stay 0.
//     - With CLKGEN_CYCLE_CNT_EN defined, cycle_cnt matches the number of rise_stb pulses seen.

Source files
------------

// File: rtl/cpu_clock_gen.sv
// Multi-channel runtime-programmable clock divider with PLL lock qualification, run/halt and single-step.
// Define CLKGEN_CYCLE_CNT_EN to add a per-channel 32-bit rise counter output (cycle_cnt).
module cpu_clock_gen #(
  parameter int NCH       = 2,
  parameter int DIVW      = 8,
  parameter int DIV_INIT  = 4,
  parameter int LOCK_WAIT = 16
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                pll_lock,
  input  logic [NCH*DIVW-1:0] div_val,
  input  logic [NCH-1:0]      div_load,
  input  logic [NCH-1:0]      run,
  input  logic [NCH-1:0]      step,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      rise_stb,
  output logic                ready
`ifdef CLKGEN_CYCLE_CNT_EN
  ,
  output logic [NCH*32-1:0]   cycle_cnt
`endif
);
  localparam int LCW = $clog2(LOCK_WAIT + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN       = 2'd1,
    IDLE      = 2'd2,
    STEP      = 2'd3
  } state_t;

  logic           r_lock_meta;
  logic           r_lock_sync;
  logic           r_ready;
  logic [LCW-1:0] r_lock_cnt;

  function automatic logic [DIVW-1:0] clamp_div(input logic [DIVW-1:0] v);
    if (v < DIVW'(2)) begin
      return DIVW'(2);
    end else begin
      return v;
    end
  endfunction

  // Lock synchroniser and qualifier: ready once LOCK_WAIT consecutive synced lock cycles are seen
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_lock_cnt  <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_sync <= r_lock_meta;
      if (!r_lock_sync) begin
        r_lock_cnt <= '0;
        r_ready    <= 1'b0;
      end else if (r_lock_cnt == LCW'(LOCK_WAIT)) begin
        r_ready    <= 1'b1;
      end else begin
        r_lock_cnt <= r_lock_cnt + LCW'(1);
        r_ready    <= 1'b0;
      end
    end
  end

  assign ready = r_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t          r_state;
    state_t          w_state;
    logic [DIVW-1:0] r_cnt, w_cnt;
    logic [DIVW-1:0] r_n, w_n;
    logic [DIVW-1:0] r_pend, w_pend;
    logic            r_clk, r_rise, w_active;

    // Next state: a period is only ever left at its last count; every new period takes the latest pending divisor
    always_comb begin
      w_pend  = div_load[c] ? clamp_div(div_val[c*DIVW +: DIVW]) : r_pend;
      w_state = r_state;
      w_cnt   = r_cnt;
      w_n     = r_n;
      case (r_state)
        RUN, STEP: begin
          if (r_cnt == r_n - DIVW'(1)) begin
            w_cnt = '0;
            w_n   = w_pend;
            if (!r_ready) begin
              w_state = WAIT_LOCK;
            end else if (run[c]) begin
              w_state = RUN;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_cnt = r_cnt + DIVW'(1);
          end
        end
        IDLE: begin
          w_cnt = '0;
          if (!r_ready) begin
            w_state = WAIT_LOCK;
          end else if (run[c]) begin
            w_state = RUN;
            w_n     = w_pend;
          end else if (step[c]) begin
            w_state = STEP;
            w_n     = w_pend;
          end else begin
            w_state = IDLE;
          end
        end
        WAIT_LOCK: begin
          w_cnt = '0;
          if (r_ready) begin
            w_n     = w_pend;
            w_state = run[c] ? RUN : IDLE;
          end else begin
            w_state = WAIT_LOCK;
          end
        end
        default: begin
          w_state = WAIT_LOCK;
          w_cnt   = '0;
        end
      endcase
      w_active = (w_state == RUN) || (w_state == STEP);
    end

    // Channel state and registered clock/strobe outputs, high phase first
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= WAIT_LOCK;
        r_cnt   <= '0;
        r_n     <= DIVW'(DIV_INIT);
        r_pend  <= DIVW'(DIV_INIT);
        r_clk   <= 1'b0;
        r_rise  <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_n     <= w_n;
        r_pend  <= w_pend;
        r_clk   <= w_active && (w_cnt < (w_n >> 1));
        r_rise  <= w_active && (w_cnt == '0);
      end
    end

    assign clk_out[c]  = r_clk;
    assign rise_stb[c] = r_rise;

`ifdef CLKGEN_CYCLE_CNT_EN
    logic [31:0] r_cyc;

    // Counts emitted rising edges, wrapping at 32 bits
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cyc <= 32'd0;
      end else if (w_active && (w_cnt == '0)) begin
        r_cyc <= r_cyc + 32'd1;
      end else begin
        r_cyc <= r_cyc;
      end
    end

    assign cycle_cnt[c*32 +: 32] = r_cyc;
`endif
  end
endmodule
